// File: rtl/cpu_pkg.sv
// Shared definitions for the datapath control sequencer: bus source codes,
// opcodes, sequencer states and small opcode classification helpers.
package cpu_pkg;

   localparam logic [4:0] SEL_HI      = 5'd16;
   localparam logic [4:0] SEL_LO      = 5'd17;
   localparam logic [4:0] SEL_ZHI     = 5'd18;
   localparam logic [4:0] SEL_ZLO     = 5'd19;
   localparam logic [4:0] SEL_PC      = 5'd20;
   localparam logic [4:0] SEL_MDR     = 5'd21;
   localparam logic [4:0] SEL_INPORT  = 5'd22;
   localparam logic [4:0] SEL_SIGNEXT = 5'd23;
   localparam logic [4:0] SEL_NONE    = 5'd31;

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_AND  = 5'd2;
   localparam logic [4:0] OP_OR   = 5'd3;
   localparam logic [4:0] OP_SHR  = 5'd4;
   localparam logic [4:0] OP_SHL  = 5'd5;
   localparam logic [4:0] OP_ROR  = 5'd6;
   localparam logic [4:0] OP_ROL  = 5'd7;
   localparam logic [4:0] OP_ADDI = 5'd8;
   localparam logic [4:0] OP_MUL  = 5'd9;
   localparam logic [4:0] OP_DIV  = 5'd10;

   typedef enum logic [3:0] {
      IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
   } state_t;

   function automatic logic op_legal(input logic [4:0] op);
      return op <= OP_DIV;
   endfunction

   // mul/div produce a 64-bit result split across LO and HI.
   function automatic logic op_muldiv(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/ir_field_latch.sv
// Holds the instruction fields for the rest of the instruction and expands
// the destination register number into a one-hot load vector.
module ir_field_latch
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        clr_n,
   input  logic        capture,
   input  logic [31:0] ir,
   output logic [4:0]  opcode,
   output logic [3:0]  ra,
   output logic [3:0]  rb,
   output logic [3:0]  rc,
   output logic [15:0] ra_onehot
);

   logic unused_ir_low;
   assign unused_ir_low = ^ir[14:0];

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         opcode <= '0;
         ra     <= '0;
         rb     <= '0;
         rc     <= '0;
      end else if (capture) begin
         opcode <= ir[31:27];
         ra     <= ir[26:23];
         rb     <= ir[22:19];
         rc     <= ir[18:15];
      end
   end

   assign ra_onehot = 16'h0001 << ra;

endmodule

// File: rtl/bus_sequencer.sv
// Multi-cycle control sequencer: fetches, decodes and steps one instruction
// per start, driving the bus source select and all datapath load enables.
module bus_sequencer
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        start,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic [4:0]  bus_sel,
   output logic        mar_in,
   output logic        inc_pc,
   output logic        mem_read,
   output logic        mdr_in,
   output logic        ir_in,
   output logic        y_in,
   output logic        z_in,
   output logic        hi_in,
   output logic        lo_in,
   output logic [4:0]  alu_op,
   output logic [15:0] reg_in,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             fault_flag;

   logic [4:0]  opcode;
   logic [3:0]  ra;
   logic [3:0]  rb;
   logic [3:0]  rc;
   logic [15:0] ra_onehot;

   ir_field_latch u_fields (
      .clk       (clk),
      .clr_n     (clr_n),
      .capture   (state == T2),
      .ir        (ir),
      .opcode    (opcode),
      .ra        (ra),
      .rb        (rb),
      .rc        (rc),
      .ra_onehot (ra_onehot)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         fault_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state      <= T0;
               fault_flag <= 1'b0;
            end
            T0: state <= T1;
            T1: begin
               if (mem_ready) begin
                  state    <= T2;
                  wait_cnt <= '0;
               end else if (MEM_TIMEOUT != 0) begin
                  if (wait_cnt == TO_LAST) begin
                     state      <= DONE;
                     fault_flag <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
               end
            end
            T2: state <= T3;
            T3: begin
               if (op_legal(opcode)) begin
                  state <= T4;
               end else begin
                  state      <= DONE;
                  fault_flag <= 1'b1;
               end
            end
            T4: state <= T5;
            T5: state <= op_muldiv(opcode) ? T6 : DONE;
            T6: state <= DONE;
            DONE: begin
               state      <= IDLE;
               wait_cnt   <= '0;
               fault_flag <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

   // NOTE: every output gets a default before the case so no path through
   // the block leaves a value unassigned, which would infer a latch.
   always_comb begin
      bus_sel  = SEL_NONE;
      mar_in   = 1'b0;
      inc_pc   = 1'b0;
      mem_read = 1'b0;
      mdr_in   = 1'b0;
      ir_in    = 1'b0;
      y_in     = 1'b0;
      z_in     = 1'b0;
      hi_in    = 1'b0;
      lo_in    = 1'b0;
      alu_op   = '0;
      reg_in   = '0;
      done     = 1'b0;
      fault    = 1'b0;
      case (state)
         T0: begin
            bus_sel = SEL_PC;
            mar_in  = 1'b1;
            inc_pc  = 1'b1;
         end
         T1: begin
            mem_read = 1'b1;
            // MDR loads in the same cycle memory reports valid data.
            mdr_in   = mem_ready;
         end
         T2: begin
            bus_sel = SEL_MDR;
            ir_in   = 1'b1;
         end
         T3: if (op_legal(opcode)) begin
            bus_sel = {1'b0, rb};
            y_in    = 1'b1;
         end
         T4: begin
            bus_sel = (opcode == OP_ADDI) ? SEL_SIGNEXT : {1'b0, rc};
            z_in    = 1'b1;
            alu_op  = opcode;
         end
         T5: begin
            bus_sel = SEL_ZLO;
            if (op_muldiv(opcode)) lo_in  = 1'b1;
            else                   reg_in = ra_onehot;
         end
         T6: begin
            bus_sel = SEL_ZHI;
            hi_in   = 1'b1;
         end
         DONE: begin
            done  = 1'b1;
            fault = fault_flag;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: stimulus queues the expected
// instruction profile, a monitor accumulates the observed one until done.
module tb_bus_sequencer;

   logic        clk;
   logic        clr_n;
   logic        start;
   logic [31:0] ir;
   logic        mem_ready;
   logic [4:0]  bus_sel;
   logic        mar_in, inc_pc, mem_read, mdr_in, ir_in;
   logic        y_in, z_in, hi_in, lo_in;
   logic [4:0]  alu_op;
   logic [15:0] reg_in;
   logic        busy, done, fault;

   int checks   = 0;
   int failures = 0;
   int mem_delay = 0;
   int wcnt      = 0;

   bus_sequencer #(.MEM_TIMEOUT(15)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .start     (start),
      .ir        (ir),
      .mem_ready (mem_ready),
      .bus_sel   (bus_sel),
      .mar_in    (mar_in),
      .inc_pc    (inc_pc),
      .mem_read  (mem_read),
      .mdr_in    (mdr_in),
      .ir_in     (ir_in),
      .y_in      (y_in),
      .z_in      (z_in),
      .hi_in     (hi_in),
      .lo_in     (lo_in),
      .alu_op    (alu_op),
      .reg_in    (reg_in),
      .busy      (busy),
      .done      (done),
      .fault     (fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: data becomes valid after mem_delay cycles of mem_read.
   always @(posedge clk) begin
      if (mem_read) wcnt <= wcnt + 1;
      else          wcnt <= 0;
   end
   assign mem_ready = mem_read && (wcnt >= mem_delay);

   typedef struct {
      int          id;
      int          lat;
      logic        fault;
      logic [59:0] sel;
      logic [59:0] selmask;
      logic [15:0] reg_or;
      int          n_mdr;
      int          n_mread;
      int          n_ir;
      int          n_y;
      int          n_z;
      int          n_lo;
      int          n_hi;
      int          n_mar;
      logic [4:0]  alu;
   } exp_t;

   exp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic string tname(input int id);
      case (id)
         0: return "add";
         1: return "sub_r0";
         2: return "mul";
         3: return "div";
         4: return "addi_wait";
         5: return "illegal31";
         6: return "illegal11";
         7: return "timeout";
         8: return "add_after_reset";
         default: return "unknown";
      endcase
   endfunction

   // Defaults describe a zero-wait three-operand ALU instruction; a trace
   // entry of -1 means the bus select is not checked in that cycle.
   function automatic exp_t base(input int id, input int tr[12]);
      exp_t e;
      e.id = id; e.lat = 7; e.fault = 1'b0;
      e.sel = '0; e.selmask = '0; e.reg_or = '0;
      e.n_mdr = 1; e.n_mread = 1; e.n_ir = 1; e.n_y = 1; e.n_z = 1;
      e.n_lo = 0; e.n_hi = 0; e.n_mar = 1; e.alu = '0;
      for (int i = 0; i < 12; i++) begin
         if (tr[i] >= 0) begin
            e.sel[i*5 +: 5]     = 5'(tr[i]);
            e.selmask[i*5 +: 5] = 5'h1f;
         end
      end
      return e;
   endfunction

   // Monitor: accumulate one instruction's observed profile, compare on done.
   int          o_lat, o_mdr, o_mread, o_ir, o_y, o_z, o_lo, o_hi, o_mar, o_pc;
   logic [59:0] o_sel;
   logic [15:0] o_reg;
   logic [4:0]  o_alu;
   logic        o_bad;
   logic        prev_done;

   task automatic clear_obs();
      o_lat = 0; o_mdr = 0; o_mread = 0; o_ir = 0; o_y = 0; o_z = 0;
      o_lo = 0; o_hi = 0; o_mar = 0; o_pc = 0;
      o_sel = '0; o_reg = '0; o_alu = '0; o_bad = 1'b0;
   endtask

   task automatic compare_obs();
      exp_t  e;
      string n;
      if (exp_q.size() == 0) begin
         check("unexpected_done", 1, 0);
      end else begin
         e = exp_q.pop_front();
         n = tname(e.id);
         check({n, ".latency"},  o_lat, e.lat);
         check({n, ".fault"},    fault, e.fault);
         check({n, ".bus_sel"},  o_sel & e.selmask, e.sel);
         check({n, ".reg_in"},   o_reg, e.reg_or);
         check({n, ".mdr_in"},   o_mdr, e.n_mdr);
         check({n, ".mem_read"}, o_mread, e.n_mread);
         check({n, ".ir_in"},    o_ir, e.n_ir);
         check({n, ".y_in"},     o_y, e.n_y);
         check({n, ".z_in"},     o_z, e.n_z);
         check({n, ".lo_in"},    o_lo, e.n_lo);
         check({n, ".hi_in"},    o_hi, e.n_hi);
         check({n, ".mar_in"},   o_mar, e.n_mar);
         check({n, ".inc_pc"},   o_pc, e.n_mar);
         check({n, ".alu_op"},   o_alu, e.alu);
         check({n, ".exclusive"}, o_bad, 1'b0);
      end
   endtask

   initial begin
      clear_obs();
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!clr_n) begin
            clear_obs();
            prev_done = 1'b0;
         end else begin
            if (prev_done) begin
               check("done_single_pulse", {busy, done, fault}, 3'b000);
               prev_done = 1'b0;
            end
            if (busy) begin
               if (o_lat < 12) o_sel[o_lat*5 +: 5] = bus_sel;
               o_lat++;
               o_mdr   += int'(mdr_in);
               o_mread += int'(mem_read);
               o_ir    += int'(ir_in);
               o_y     += int'(y_in);
               o_z     += int'(z_in);
               o_lo    += int'(lo_in);
               o_hi    += int'(hi_in);
               o_mar   += int'(mar_in);
               o_pc    += int'(inc_pc);
               o_reg   |= reg_in;
               if (z_in) o_alu = alu_op;
               if ((int'(y_in) + int'(z_in) + int'(ir_in) + int'(mdr_in) + int'(hi_in)
                    + int'(lo_in) + $countones(reg_in)) > 1) o_bad = 1'b1;
               if (!z_in && alu_op != 5'd0) o_bad = 1'b1;
               if (fault && !done) o_bad = 1'b1;
               if (done) begin
                  compare_obs();
                  clear_obs();
                  prev_done = 1'b1;
               end
            end
         end
      end
   end

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_budget", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic run(input exp_t e, input logic [31:0] irv, input int dly);
      ir        = irv;
      mem_delay = dly;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   tr[12];

      clr_n = 1'b0;
      start = 1'b0;
      ir    = '0;
      #1;
      check("reset.bus_sel", bus_sel, 5'd31);
      check("reset.outputs",
            {busy, done, fault, mar_in, inc_pc, mem_read, mdr_in, ir_in,
             y_in, z_in, hi_in, lo_in, alu_op, reg_in}, '0);
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);

      // add r1,r2,r3
      tr = '{20, -1, 21, 2, 3, 19, 31, -1, -1, -1, -1, -1};
      e = base(0, tr); e.reg_or = 16'h0002; e.alu = 5'd0;
      run(e, 32'h0091_8000, 0);

      // sub r0,r5,r6: r0 is a legal destination
      tr = '{20, -1, 21, 5, 6, 19, 31, -1, -1, -1, -1, -1};
      e = base(1, tr); e.reg_or = 16'h0001; e.alu = 5'd1;
      run(e, 32'h082B_0000, 0);

      // mul r0,r4,r5
      tr = '{20, -1, 21, 4, 5, 19, 18, 31, -1, -1, -1, -1};
      e = base(2, tr); e.lat = 8; e.n_lo = 1; e.n_hi = 1; e.alu = 5'd9;
      run(e, 32'h4822_8000, 0);

      // div r3,r1,r2
      tr = '{20, -1, 21, 1, 2, 19, 18, 31, -1, -1, -1, -1};
      e = base(3, tr); e.lat = 8; e.n_lo = 1; e.n_hi = 1; e.alu = 5'd10;
      run(e, 32'h5189_0000, 0);

      // addi r7,r6,imm with three memory wait cycles
      tr = '{20, -1, -1, -1, -1, 21, 6, 23, 19, 31, -1, -1};
      e = base(4, tr); e.lat = 10; e.n_mread = 4; e.reg_or = 16'h0080; e.alu = 5'd8;
      run(e, 32'h43B0_0000, 3);

      // opcode 31: decode aborts with fault, no datapath strobes
      tr = '{20, -1, 21, -1, 31, -1, -1, -1, -1, -1, -1, -1};
      e = base(5, tr); e.lat = 5; e.fault = 1'b1; e.n_y = 0; e.n_z = 0;
      run(e, 32'hF800_0000, 0);

      // opcode 11: first value past the legal range
      tr = '{20, -1, 21, -1, 31, -1, -1, -1, -1, -1, -1, -1};
      e = base(6, tr); e.lat = 5; e.fault = 1'b1; e.n_y = 0; e.n_z = 0;
      run(e, 32'h5800_0000, 0);

      // memory never answers: 15 T1 cycles then faulting done
      tr = '{20, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
      e = base(7, tr); e.lat = 17; e.fault = 1'b1; e.n_mread = 15;
      e.n_mdr = 0; e.n_ir = 0; e.n_y = 0; e.n_z = 0;
      run(e, 32'h0091_8000, 1000);

      // asynchronous reset in T4, then a fresh fetch with start held
      ir        = 32'h0091_8000;
      mem_delay = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("abort.t4_z_in", {z_in, bus_sel}, {1'b1, 5'd3});
      #1 clr_n = 1'b0;
      #1;
      check("abort.bus_sel", bus_sel, 5'd31);
      check("abort.outputs",
            {busy, done, fault, mar_in, inc_pc, mem_read, mdr_in, ir_in,
             y_in, z_in, hi_in, lo_in, alu_op, reg_in}, '0);
      tr = '{20, -1, 21, 2, 3, 19, 31, -1, -1, -1, -1, -1};
      e = base(8, tr); e.reg_or = 16'h0002;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b1;
      #2 clr_n = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
